// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO and its RAM.
package sync_fifo_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int fifo_cnt_w(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// Single-clock RAM with registered read; a same-address read and write return the old word.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem_q [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[write_addr] <= data_in;
    if (re) data_out <= mem_q[read_addr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flag decode and error pulses around fifo_ram.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = fifo_cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
  localparam logic [CW-1:0] AF_LVL  = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL  = CW'(ALMOST_EMPTY_LEVEL);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  valid_q, ovf_q, udf_q, rd_seen_q;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign data_valid   = valid_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  // The RAM output register has no reset; show zero until the first read after reset.
  assign data_out     = rd_seen_q ? ram_dout : '0;

  always_comb begin
    rd_ok   = re && !empty && !reset;
    wr_ok   = we && (!full || rd_ok) && !reset;
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q   <= count_d;
      valid_q   <= rd_ok;
      ovf_q     <= we && !wr_ok;
      udf_q     <= re && !rd_ok;
      rd_seen_q <= rd_seen_q || rd_ok;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .we        (wr_ok),
    .write_addr(wr_ptr_q),
    .data_in   (data_in),
    .re        (rd_ok),
    .read_addr (rd_ptr_q),
    .data_out  (ram_dout)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: fixed vector table, then directed and random traffic against a queue model.
module tb_sync_fifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          we = 1'b0, re = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int ncmp = 0;
  int nerr = 0;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .we(we), .re(re),
    .data_out(data_out), .data_valid(data_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rst, w, r;
    logic [DW-1:0] d;
    int            e_count;
    logic          e_empty, e_full, e_valid;
    logic [DW-1:0] e_dout;
    logic          e_ovf, e_udf;
  } vec_t;

  // Reference model: a plain queue of words plus the last delivered word.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

  task automatic step(input logic r, input logic w, input logic rr, input logic [DW-1:0] d);
    bit rok, wok;
    int sz;
    reset = r; we = w; re = rr; data_in = d;
    @(posedge clk); #1;
    if (r) begin
      mq.delete();
      m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      rok = rr && (mq.size() > 0);
      wok = w && ((mq.size() < DEPTH) || rok);
      m_valid = rok;
      if (rok) m_dout = mq.pop_front();
      if (wok) mq.push_back(d);
      m_ovf = w && !wok;
      m_udf = rr && !rok;
    end
    sz = mq.size();
    chk("count", 32'(count), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
    chk("data_valid", 32'(data_valid), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
  endtask

  initial begin
    vec_t tbl[12];
    logic [DW-1:0] pat;
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1};
    tbl[3]  = '{0, 1, 0, 8'h11, 1, 0, 0, 0, 8'h00, 0, 0};
    tbl[4]  = '{0, 1, 1, 8'h22, 1, 0, 0, 1, 8'h11, 0, 0};
    tbl[5]  = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 8'h22, 0, 0};
    tbl[6]  = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h22, 0, 0};
    tbl[7]  = '{0, 1, 1, 8'h55, 1, 0, 0, 0, 8'h22, 0, 1};
    tbl[8]  = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 8'h55, 0, 0};
    tbl[9]  = '{0, 1, 0, 8'h66, 1, 0, 0, 0, 8'h55, 0, 0};
    tbl[10] = '{1, 1, 1, 8'h77, 0, 1, 0, 0, 8'h00, 0, 0};
    tbl[11] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1};

    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst; we = tbl[i].w; re = tbl[i].r; data_in = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d valid", i), 32'(data_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d dout", i), 32'(data_out), 32'(tbl[i].e_dout));
      chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d udf", i), 32'(underflow), 32'(tbl[i].e_udf));
    end

    // Fill past full, drain past empty.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, DW'(i));
    chk("count after overfill", 32'(count), 32'(16));
    for (int i = 0; i < 17; i++) step(0, 0, 1, 0);
    chk("empty after drain", 32'(empty), 32'(1));

    // Simultaneous access at full, then drain to find 0xAA last.
    for (int i = 0; i < 16; i++) step(0, 1, 0, DW'(8'h40 + i));
    step(0, 1, 1, 8'hAA);
    chk("full-rw oldest", 32'(data_out), 32'(8'h40));
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    chk("full-rw 0xAA last", 32'(data_out), 32'(8'hAA));

    // Simultaneous access at empty.
    step(0, 1, 1, 8'h55);
    step(0, 0, 1, 0);
    chk("empty-rw readback", 32'(data_out), 32'(8'h55));

    // Streaming at occupancy 5 across many pointer wraps.
    pat = 8'h00;
    for (int i = 0; i < 5; i++) begin step(0, 1, 0, pat); pat++; end
    for (int i = 0; i < 100; i++) begin step(0, 1, 1, pat); pat++; end
    chk("stream lag", 32'(data_out), 32'(DW'(pat - 8'd6)));

    // Reset mid-stream with requests pending.
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hEE);
    step(1, 1, 1, 8'h99);
    step(0, 1, 0, 8'h3C);
    step(0, 0, 1, 0);
    chk("post-reset word", 32'(data_out), 32'(8'h3C));

    // Random traffic with phases biased toward full and empty.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 200) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < wp),
           ($urandom_range(0, 99) < 100 - wp),
           DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
